// File: rtl/pix_frame_rx.sv
// Image-frame receiver: turns the UART byte stream into pixel RAM writes, with
// a per-row check code, an end-of-frame checksum, an idle timeout and an abort.
module pix_frame_rx #(
    parameter int          W           = 50,
    parameter int          H           = 40,
    parameter int          PIX_BYTES   = 2,
    parameter int          PIX_W       = 12,
    parameter logic [7:0]  HDR_BYTE    = 8'hA5,
    parameter int          TIMEOUT_CYC = 5_000_000,
    parameter int          ADDR_W      = $clog2(W * H)
) (
    input  logic              i_clk_sys,
    input  logic              i_rst_n,
    input  logic              i_enable,
    input  logic              i_abort,
    input  logic [7:0]        i_rx_data,
    input  logic              i_rx_done,
    output logic              o_busy,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wr_addr,
    output logic [PIX_W-1:0]  o_wr_data,
    output logic [7:0]        o_check_code,
    output logic              o_check_valid,
    output logic              o_frame_done,
    output logic              o_frame_err,
    output logic [ADDR_W:0]   o_pix_cnt
);

    localparam int AW = 8 * PIX_BYTES;
    localparam int CW = (W > 1) ? $clog2(W) : 1;
    localparam int BW = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(W * H - 1);
    localparam logic [CW-1:0]     LAST_COL  = CW'(W - 1);
    localparam logic [BW-1:0]     LAST_BYTE = BW'(PIX_BYTES - 1);
    localparam logic [TW-1:0]     TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PIXEL = 2'd1, ST_CKSUM = 2'd2} state_t;

    state_t             state_r, state_next_s;
    logic [BW-1:0]      byte_idx_r;
    logic [CW-1:0]      col_r;
    logic [ADDR_W-1:0]  addr_r;
    logic [AW-1:0]      asm_r;
    logic [7:0]         row_sum_r, frame_sum_r;
    logic [TW-1:0]      idle_cnt_r;
    logic               busy_r, wr_en_r, check_valid_r, frame_done_r, frame_err_r;
    logic [ADDR_W-1:0]  wr_addr_r;
    logic [PIX_W-1:0]   wr_data_r;
    logic [7:0]         check_code_r;
    logic [ADDR_W:0]    pix_cnt_r;

    logic               hdr_s, pix_byte_s, ck_byte_s, tmo_s;
    logic               last_byte_s, last_col_s, last_addr_s, idle_expired_s;
    logic [AW-1:0]      asm_next_s;
    logic [7:0]         row_sum_next_s;

    assign last_byte_s    = (byte_idx_r == LAST_BYTE);
    assign last_col_s     = (col_r == LAST_COL);
    assign last_addr_s    = (addr_r == LAST_ADDR);
    assign idle_expired_s = (idle_cnt_r == TMO_LAST);
    // First byte of a pixel ends up most significant.
    assign asm_next_s     = (asm_r << 8) | AW'(i_rx_data);
    assign row_sum_next_s = row_sum_r + i_rx_data;

    // Frame state register.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next state and per-cycle events; abort or loss of enable outranks a byte.
    always_comb begin
        state_next_s = state_r;
        hdr_s        = 1'b0;
        pix_byte_s   = 1'b0;
        ck_byte_s    = 1'b0;
        tmo_s        = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!i_abort && i_enable && i_rx_done && (i_rx_data == HDR_BYTE)) begin
                    hdr_s        = 1'b1;
                    state_next_s = ST_PIXEL;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_PIXEL: begin
                if (i_abort || !i_enable) begin
                    state_next_s = ST_IDLE;
                end else if (i_rx_done) begin
                    pix_byte_s   = 1'b1;
                    state_next_s = (last_byte_s && last_addr_s) ? ST_CKSUM : ST_PIXEL;
                end else if (idle_expired_s) begin
                    tmo_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_PIXEL;
                end
            end
            ST_CKSUM: begin
                if (i_abort || !i_enable) begin
                    state_next_s = ST_IDLE;
                end else if (i_rx_done) begin
                    ck_byte_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (idle_expired_s) begin
                    tmo_s        = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_CKSUM;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Pixel assembly, addressing, sums, idle timer and registered outputs.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            byte_idx_r    <= '0;
            col_r         <= '0;
            addr_r        <= '0;
            asm_r         <= '0;
            row_sum_r     <= 8'd0;
            frame_sum_r   <= 8'd0;
            idle_cnt_r    <= '0;
            busy_r        <= 1'b0;
            wr_en_r       <= 1'b0;
            wr_addr_r     <= '0;
            wr_data_r     <= '0;
            check_code_r  <= 8'd0;
            check_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            pix_cnt_r     <= '0;
        end else begin
            wr_en_r       <= 1'b0;
            check_valid_r <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_err_r   <= 1'b0;
            busy_r        <= (state_next_s != ST_IDLE);
            if (hdr_s) begin
                byte_idx_r  <= '0;
                col_r       <= '0;
                addr_r      <= '0;
                row_sum_r   <= 8'd0;
                frame_sum_r <= 8'd0;
                pix_cnt_r   <= '0;
                idle_cnt_r  <= TW'(1);
            end else if (pix_byte_s) begin
                asm_r       <= asm_next_s;
                frame_sum_r <= frame_sum_r + i_rx_data;
                idle_cnt_r  <= TW'(1);
                if (last_byte_s) begin
                    byte_idx_r <= '0;
                    wr_en_r    <= 1'b1;
                    wr_addr_r  <= addr_r;
                    wr_data_r  <= asm_next_s[PIX_W-1:0];
                    addr_r     <= last_addr_s ? addr_r : addr_r + ADDR_W'(1);
                    pix_cnt_r  <= pix_cnt_r + (ADDR_W + 1)'(1);
                    if (last_col_s) begin
                        check_valid_r <= 1'b1;
                        check_code_r  <= row_sum_next_s;
                        row_sum_r     <= 8'd0;
                        col_r         <= '0;
                    end else begin
                        row_sum_r     <= row_sum_next_s;
                        col_r         <= col_r + CW'(1);
                    end
                end else begin
                    byte_idx_r <= byte_idx_r + BW'(1);
                    row_sum_r  <= row_sum_next_s;
                end
            end else if (ck_byte_s) begin
                if (i_rx_data == frame_sum_r) begin
                    frame_done_r <= 1'b1;
                end else begin
                    frame_err_r  <= 1'b1;
                end
            end else if (tmo_s) begin
                frame_err_r <= 1'b1;
            end else if (state_r != ST_IDLE) begin
                idle_cnt_r <= idle_cnt_r + TW'(1);
            end else begin
                idle_cnt_r <= '0;
            end
        end
    end

    assign o_busy        = busy_r;
    assign o_wr_en       = wr_en_r;
    assign o_wr_addr     = wr_addr_r;
    assign o_wr_data     = wr_data_r;
    assign o_check_code  = check_code_r;
    assign o_check_valid = check_valid_r;
    assign o_frame_done  = frame_done_r;
    assign o_frame_err   = frame_err_r;
    assign o_pix_cnt     = pix_cnt_r;

endmodule
